idli_sqi_mem_m: RTL and testbench
=================================

Name: idli_sqi_mem_m

Overview:
- Synthesisable responder for the SQI serial SRAM protocol that the core drives on its low/high memory ports. It is the device end of the mem_lo/mem_hi interface.
- Byte-addressed storage supporting sequential READ (0x03) and WRITE (0x02) in quad mode.
- Benches instantiate two copies, one per memory half.
- Has a backdoor port for program preload and for inspecting contents.

Parameters:
- ADDR_W, 17, byte address width; storage is 2**ADDR_W bytes and addresses wrap modulo this size.
- DUMMY_NIB, 2, number of dummy nibbles between the last address nibble and the first read data nibble.

Ports:
- i_mem_gck  in  1  clock; all logic on its rising edge.
- i_mem_rst_n  in  1  reset, synchronous, active-low.
- i_mem_sck  in  1  SQI serial clock from the initiator, sampled on gck; each level must hold for at least one gck cycle.
- i_mem_cs  in  1  chip select, active-low.
- i_mem_sio  in  4  nibble from the initiator (slice_t).
- o_mem_sio  out  4  nibble to the initiator (slice_t).
- o_mem_sio_oe  out  1  high while the responder drives o_mem_sio.
- o_mem_err  out  1  sticky flag: an unsupported instruction was received.
- i_mem_bd_we  in  1  backdoor write strobe.
- i_mem_bd_addr  in  ADDR_W  backdoor byte address, used for both read and write.
- i_mem_bd_wdata  in  8  backdoor write data.
- o_mem_bd_rdata  out  8  mem[i_mem_bd_addr], combinational read.

Behaviour:
- Edge detection:
  - sck_q holds i_mem_sck registered.
  - Rise = !sck_q & i_mem_sck. Fall = sck_q & !i_mem_sck.
  - All protocol actions occur in the gck cycle in which an edge is detected.
- Reset (rst_n low at a gck edge):
  - State goes to IDLE; o_mem_sio=0, o_mem_sio_oe=0, o_mem_err=0, sck_q=0, counters=0.
  - Memory contents are not cleared.
  - Reset mid-transaction aborts it; no partial byte is committed.
- CS high, sampled at any gck edge:
  - Next state is IDLE and o_mem_sio_oe=0 in the next cycle.
  - Any pending half byte is discarded.
  - CS high overrides a simultaneous sck edge.
- States and transitions (each "nibble" is one Rise with CS low; nibbles arrive MSB first):
  - IDLE: CS low goes to INSTR with the nibble count cleared.
  - INSTR: 2 nibbles form the instruction byte.
    - 0x03 goes to ADDR with the read flag set.
    - 0x02 goes to ADDR with the read flag clear.
    - Any other value sets o_mem_err and goes to IGNORE.
  - ADDR: 6 nibbles form a 24-bit address; bits above ADDR_W-1 are ignored.
    - Read goes to DUMMY.
    - Write goes to WDATA.
  - DUMMY: after DUMMY_NIB rises (i_mem_sio ignored), go to RDATA.
  - RDATA: driven on Fall, not on Rise.
    - On each Fall, drive the next nibble and set oe=1: high nibble of mem[addr], then low nibble.
    - After the low nibble, addr = addr+1 mod 2**ADDR_W.
    - The first Fall after the final dummy Rise drives the high nibble, so it is stable for the next Rise.
    - o_mem_sio holds between Falls.
  - WDATA: the high nibble is latched on a Rise.
    - On the next Rise, the full byte is written to mem[addr] in that cycle and addr increments with wrap.
  - IGNORE: all sck activity is ignored until CS goes high.
- The read path outputs registered data only; there are no glitches on o_mem_sio.
- The nibble counter is 3 bits; it is reset on every state change.
- Backdoor:
  - i_mem_bd_we is honoured only while CS is high; otherwise it is ignored.
  - The write takes effect on the gck edge; rdata reflects it in the next cycle.
- o_mem_err clears only on reset.

Test Plan:
- Preload via backdoor: 0x00010=0xA5, 0x00011=0x3C. Issue READ of 0x000010, 2 dummy nibbles, 4 data nibbles -> sio nibbles A,5,3,C sampled on successive Rises; oe=1 from the first data Fall until 1 cycle after CS high.
- WRITE 0x0001FF, data nibbles 1,2,3,4; CS high -> backdoor reads mem[0x1FF]=0x12 and mem[0x200]=0x34.
- WRITE at 0x01FFFF (top, ADDR_W=17) with 2 bytes 0xDE,0xAD -> mem[0x1FFFF]=0xDE, mem[0x00000]=0xAD (wrap). Address bits 23:17 set to 1 are ignored.
- WRITE of 3 nibbles (7,8,9) to 0x40, then CS high -> mem[0x40]=0x78, mem[0x41] unchanged; next IDLE→INSTR starts cleanly.
- Instruction 0x05 -> o_mem_err=1 next cycle; subsequent nibbles ignored and oe stays 0; a following READ still works and err stays 1 until rst_n is pulsed low.
- Reset asserted mid-READ (after 2 data nibbles) -> next cycle oe=0, o_mem_sio=0, state IDLE; memory unchanged; a subsequent READ returns the correct data.

Source files
------------

// File: rtl/idli_sqi_mem_m.sv
// ---------------------------------------------------------------------------
// idli_sqi_mem_m
//
// Device-side responder for the quad-mode SQI serial SRAM protocol. It
// supports sequential READ (0x03) and WRITE (0x02) over a byte-addressed store
// of 2**ADDR_W bytes. Addresses wrap modulo the store size. A backdoor port
// preloads and inspects memory contents.
//
// Ports:
//   i_mem_gck      system clock; every flop updates on its rising edge
//   i_mem_rst_n    synchronous active-low reset (memory contents are kept)
//   i_mem_sck      serial clock from the initiator, oversampled on gck
//   i_mem_cs       chip select, active-low
//   i_mem_sio      nibble from the initiator
//   o_mem_sio      nibble to the initiator (registered)
//   o_mem_sio_oe   high while o_mem_sio is being driven
//   o_mem_err      sticky: an unsupported instruction was seen
//   i_mem_bd_we    backdoor write strobe (honoured only while CS is high)
//   i_mem_bd_addr  backdoor byte address for both read and write
//   i_mem_bd_wdata backdoor write data
//   o_mem_bd_rdata combinational read of mem[i_mem_bd_addr]
// ---------------------------------------------------------------------------
module idli_sqi_mem_m #(
    parameter int ADDR_W    = 17,
    parameter int DUMMY_NIB = 2
) (
    input  logic              i_mem_gck,
    input  logic              i_mem_rst_n,
    input  logic              i_mem_sck,
    input  logic              i_mem_cs,
    input  logic [3:0]        i_mem_sio,
    output logic [3:0]        o_mem_sio,
    output logic              o_mem_sio_oe,
    output logic              o_mem_err,
    input  logic              i_mem_bd_we,
    input  logic [ADDR_W-1:0] i_mem_bd_addr,
    input  logic [7:0]        i_mem_bd_wdata,
    output logic [7:0]        o_mem_bd_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INSTR,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } state_t;

    localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_NIB - 1);

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    state_t            state_q, state_d;
    logic              sck_q, sck_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [19:0]       sh_q, sh_d;      // last five received nibbles
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;      // 1 = READ, 0 = WRITE
    logic [3:0]        hi_q, hi_d;      // pending high nibble of a write byte
    logic [3:0]        sio_q, sio_d;
    logic              oe_q, oe_d;
    logic              err_q, err_d;

    logic              rise, fall;
    state_t            cur;
    logic [23:0]       word;
    logic [7:0]        rd_byte;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;

    assign rise    = !sck_q &&  i_mem_sck;
    assign fall    =  sck_q && !i_mem_sck;
    // Incoming nibble appended to the history: the complete instruction or
    // address on the cycle its last nibble arrives.
    assign word    = {sh_q, i_mem_sio};
    assign rd_byte = mem[addr_q];

    always_comb begin
        state_d   = state_q;
        sck_d     = i_mem_sck;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        addr_d    = addr_q;
        rd_d      = rd_q;
        hi_d      = hi_q;
        sio_d     = sio_q;
        oe_d      = oe_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = i_mem_bd_addr;
        mem_wdata = i_mem_bd_wdata;
        // IDLE with CS low behaves as INSTR. A rise in that same cycle then
        // counts as the first instruction nibble.
        cur       = (state_q == ST_IDLE) ? ST_INSTR : state_q;

        if (i_mem_cs) begin
            // Deselect wins over any sck edge and drops a pending half byte.
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
            oe_d    = 1'b0;
            mem_we  = i_mem_bd_we;
        end else begin
            state_d = cur;
            unique case (cur)
                ST_INSTR: begin
                    if (rise) begin
                        sh_d = word[19:0];
                        if (cnt_q == 3'd0) begin
                            cnt_d = 3'd1;
                        end else begin
                            cnt_d = 3'd0;
                            if (word[7:0] == 8'h03) begin
                                rd_d    = 1'b1;
                                state_d = ST_ADDR;
                            end else if (word[7:0] == 8'h02) begin
                                rd_d    = 1'b0;
                                state_d = ST_ADDR;
                            end else begin
                                err_d   = 1'b1;
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR: begin
                    if (rise) begin
                        sh_d = word[19:0];
                        if (cnt_q == 3'd5) begin
                            cnt_d  = 3'd0;
                            // Upper address bits beyond the store are dropped.
                            addr_d = word[ADDR_W-1:0];
                            if (!rd_q) begin
                                state_d = ST_WDATA;
                            end else if (DUMMY_NIB == 0) begin
                                state_d = ST_RDATA;
                            end else begin
                                state_d = ST_DUMMY;
                            end
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (rise) begin
                        if (cnt_q == DUMMY_LAST) begin
                            cnt_d   = 3'd0;
                            state_d = ST_RDATA;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                ST_RDATA: begin
                    // Data changes on the fall so it is stable at the next rise.
                    if (fall) begin
                        oe_d = 1'b1;
                        if (!cnt_q[0]) begin
                            sio_d = rd_byte[7:4];
                            cnt_d = 3'd1;
                        end else begin
                            sio_d  = rd_byte[3:0];
                            cnt_d  = 3'd0;
                            addr_d = addr_q + ADDR_W'(1);
                        end
                    end
                end
                ST_WDATA: begin
                    if (rise) begin
                        if (!cnt_q[0]) begin
                            hi_d  = i_mem_sio;
                            cnt_d = 3'd1;
                        end else begin
                            // A reset on this edge aborts the byte.
                            mem_we    = i_mem_rst_n;
                            mem_waddr = addr_q;
                            mem_wdata = {hi_q, i_mem_sio};
                            addr_d    = addr_q + ADDR_W'(1);
                            cnt_d     = 3'd0;
                        end
                    end
                end
                ST_IGNORE: begin
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge i_mem_gck) begin
        if (!i_mem_rst_n) begin
            state_q <= ST_IDLE;
            sck_q   <= 1'b0;
            cnt_q   <= 3'd0;
            sh_q    <= 20'd0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            hi_q    <= 4'd0;
            sio_q   <= 4'd0;
            oe_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sck_q   <= sck_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            hi_q    <= hi_d;
            sio_q   <= sio_d;
            oe_q    <= oe_d;
            err_q   <= err_d;
        end
    end

    // Storage has no reset so preloaded contents survive rst_n.
    always_ff @(posedge i_mem_gck) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign o_mem_sio      = sio_q;
    assign o_mem_sio_oe   = oe_q;
    assign o_mem_err      = err_q;
    assign o_mem_bd_rdata = mem[i_mem_bd_addr];

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// ---------------------------------------------------------------------------
// tb_idli_sqi_mem_m
//
// Directed testbench for idli_sqi_mem_m: the initiator side of SQI is driven
// from tasks, and each scenario task checks its own expected values.
// ---------------------------------------------------------------------------
module tb_idli_sqi_mem_m;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck = 1'b0;
    logic        cs = 1'b1;
    logic [3:0]  sio_in = 4'd0;
    logic [3:0]  sio_out;
    logic        sio_oe;
    logic        err;
    logic        bd_we = 1'b0;
    logic [16:0] bd_addr = 17'd0;
    logic [7:0]  bd_wdata = 8'd0;
    logic [7:0]  bd_rdata;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] rd_buf [8];
    logic       rd_oe  [8];

    idli_sqi_mem_m #(.ADDR_W(17), .DUMMY_NIB(2)) dut (
        .i_mem_gck      (clk),
        .i_mem_rst_n    (rst_n),
        .i_mem_sck      (sck),
        .i_mem_cs       (cs),
        .i_mem_sio      (sio_in),
        .o_mem_sio      (sio_out),
        .o_mem_sio_oe   (sio_oe),
        .o_mem_err      (err),
        .i_mem_bd_we    (bd_we),
        .i_mem_bd_addr  (bd_addr),
        .i_mem_bd_wdata (bd_wdata),
        .o_mem_bd_rdata (bd_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_nib(input logic [3:0] n);
        sio_in = n;
        sck = 1'b1;
        tick(2);
        sck = 1'b0;
        tick(2);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_nib(b[7:4]);
        send_nib(b[3:0]);
    endtask

    task automatic send_hdr(input logic [7:0] instr, input logic [23:0] a);
        cs = 1'b0;
        tick(1);
        send_byte(instr);
        for (int i = 5; i >= 0; i--) send_nib(a[i*4 +: 4]);
    endtask

    task automatic rd_nib(output logic [3:0] n, output logic oe);
        n  = sio_out;
        oe = sio_oe;
        sck = 1'b1;
        tick(2);
        sck = 1'b0;
        tick(2);
    endtask

    task automatic end_txn();
        cs = 1'b1;
        tick(2);
    endtask

    task automatic bd_write(input logic [16:0] a, input logic [7:0] d);
        bd_addr  = a;
        bd_wdata = d;
        bd_we    = 1'b1;
        tick(1);
        bd_we    = 1'b0;
    endtask

    task automatic bd_read(input logic [16:0] a, output logic [7:0] d);
        bd_addr = a;
        #1;
        d = bd_rdata;
    endtask

    // Full READ: header, two dummy nibbles, n data nibbles into rd_buf/rd_oe.
    task automatic do_read(input logic [23:0] a, input int n);
        logic [3:0] nb;
        logic       oe;
        send_hdr(8'h03, a);
        send_nib(4'h0);
        send_nib(4'h0);
        for (int i = 0; i < n; i++) begin
            rd_nib(nb, oe);
            rd_buf[i] = nb;
            rd_oe[i]  = oe;
        end
        end_txn();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        vectors++;
        if (sio_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_oe: got %b expected 0", sio_oe);
        end
        vectors++;
        if (sio_out !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_sio: got %h expected 0", sio_out);
        end
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err: got %b expected 0", err);
        end
        rst_n = 1'b1;
        tick(1);
        $display("test_reset done");
    endtask

    task automatic test_backdoor();
        logic [7:0] d;
        bd_write(17'h00010, 8'hA5);
        bd_write(17'h00011, 8'h3C);
        bd_read(17'h00010, d);
        vectors++;
        if (d !== 8'hA5) begin
            miscompares++;
            $display("FAIL bd_0x10: got %h expected a5", d);
        end
        bd_read(17'h00011, d);
        vectors++;
        if (d !== 8'h3C) begin
            miscompares++;
            $display("FAIL bd_0x11: got %h expected 3c", d);
        end
        $display("test_backdoor done");
    endtask

    task automatic test_read();
        logic [3:0] exp_nib [4];
        logic [3:0] nb;
        logic       oe;
        exp_nib = '{4'hA, 4'h5, 4'h3, 4'hC};
        send_hdr(8'h03, 24'h000010);
        vectors++;
        if (sio_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL read_oe_hdr: got %b expected 0", sio_oe);
        end
        send_nib(4'h0);
        send_nib(4'h0);
        for (int i = 0; i < 4; i++) begin
            rd_nib(nb, oe);
            vectors++;
            if (nb !== exp_nib[i] || oe !== 1'b1) begin
                miscompares++;
                $display("FAIL read_nib%0d: got %h oe=%b expected %h oe=1", i, nb, oe, exp_nib[i]);
            end
        end
        cs = 1'b1;
        #1;
        vectors++;
        if (sio_oe !== 1'b1) begin
            miscompares++;
            $display("FAIL read_oe_cs_rise: got %b expected 1", sio_oe);
        end
        tick(1);
        vectors++;
        if (sio_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL read_oe_after_cs: got %b expected 0", sio_oe);
        end
        tick(1);
        $display("test_read done");
    endtask

    task automatic test_write_cross();
        logic [7:0] d;
        send_hdr(8'h02, 24'h0001FF);
        send_nib(4'h1);
        send_nib(4'h2);
        send_nib(4'h3);
        send_nib(4'h4);
        end_txn();
        bd_read(17'h001FF, d);
        vectors++;
        if (d !== 8'h12) begin
            miscompares++;
            $display("FAIL write_0x1ff: got %h expected 12", d);
        end
        bd_read(17'h00200, d);
        vectors++;
        if (d !== 8'h34) begin
            miscompares++;
            $display("FAIL write_0x200: got %h expected 34", d);
        end
        $display("test_write_cross done");
    endtask

    task automatic test_write_wrap();
        logic [7:0] d;
        // Bits 23:17 set as well; only the low 17 bits select the byte.
        send_hdr(8'h02, 24'hFFFFFF);
        send_byte(8'hDE);
        send_byte(8'hAD);
        end_txn();
        bd_read(17'h1FFFF, d);
        vectors++;
        if (d !== 8'hDE) begin
            miscompares++;
            $display("FAIL wrap_top: got %h expected de", d);
        end
        bd_read(17'h00000, d);
        vectors++;
        if (d !== 8'hAD) begin
            miscompares++;
            $display("FAIL wrap_zero: got %h expected ad", d);
        end
        $display("test_write_wrap done");
    endtask

    task automatic test_partial();
        logic [7:0] d;
        bd_write(17'h00041, 8'h55);
        send_hdr(8'h02, 24'h000040);
        send_nib(4'h7);
        send_nib(4'h8);
        send_nib(4'h9);
        end_txn();
        bd_read(17'h00040, d);
        vectors++;
        if (d !== 8'h78) begin
            miscompares++;
            $display("FAIL partial_0x40: got %h expected 78", d);
        end
        bd_read(17'h00041, d);
        vectors++;
        if (d !== 8'h55) begin
            miscompares++;
            $display("FAIL partial_0x41: got %h expected 55", d);
        end
        do_read(24'h000040, 2);
        vectors++;
        if (rd_buf[0] !== 4'h7 || rd_buf[1] !== 4'h8) begin
            miscompares++;
            $display("FAIL partial_readback: got %h%h expected 78", rd_buf[0], rd_buf[1]);
        end
        $display("test_partial done");
    endtask

    task automatic test_bd_blocked();
        logic [7:0] d;
        bd_write(17'h00050, 8'h11);
        cs = 1'b0;
        tick(1);
        bd_write(17'h00050, 8'h99);
        cs = 1'b1;
        tick(2);
        bd_read(17'h00050, d);
        vectors++;
        if (d !== 8'h11) begin
            miscompares++;
            $display("FAIL bd_blocked: got %h expected 11", d);
        end
        $display("test_bd_blocked done");
    endtask

    task automatic test_bad_instr();
        logic [3:0] junk [8];
        junk = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
        cs = 1'b0;
        tick(1);
        send_nib(4'h0);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_early: got %b expected 0", err);
        end
        sio_in = 4'h5;
        sck = 1'b1;
        tick(1);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_set: got %b expected 1", err);
        end
        tick(1);
        sck = 1'b0;
        tick(2);
        for (int i = 0; i < 8; i++) begin
            send_nib(junk[i]);
            vectors++;
            if (sio_oe !== 1'b0) begin
                miscompares++;
                $display("FAIL ignore_oe%0d: got %b expected 0", i, sio_oe);
            end
        end
        end_txn();
        do_read(24'h000010, 2);
        vectors++;
        if (rd_buf[0] !== 4'hA || rd_buf[1] !== 4'h5 || rd_oe[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL read_after_err: got %h%h oe=%b expected a5 oe=1", rd_buf[0], rd_buf[1], rd_oe[0]);
        end
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: got %b expected 1", err);
        end
        $display("test_bad_instr done");
    endtask

    task automatic test_reset_mid_read();
        logic [3:0] nb;
        logic       oe;
        logic [7:0] d;
        logic [3:0] exp_nib [4];
        exp_nib = '{4'hA, 4'h5, 4'h3, 4'hC};
        send_hdr(8'h03, 24'h000010);
        send_nib(4'h0);
        send_nib(4'h0);
        rd_nib(nb, oe);
        rd_nib(nb, oe);
        rst_n = 1'b0;
        tick(1);
        vectors++;
        if (sio_oe !== 1'b0 || sio_out !== 4'h0) begin
            miscompares++;
            $display("FAIL rst_mid_out: got oe=%b sio=%h expected oe=0 sio=0", sio_oe, sio_out);
        end
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_clears_err: got %b expected 0", err);
        end
        rst_n = 1'b1;
        cs = 1'b1;
        tick(2);
        bd_read(17'h00010, d);
        vectors++;
        if (d !== 8'hA5) begin
            miscompares++;
            $display("FAIL rst_mem_kept: got %h expected a5", d);
        end
        do_read(24'h000010, 4);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (rd_buf[i] !== exp_nib[i] || rd_oe[i] !== 1'b1) begin
                miscompares++;
                $display("FAIL reread_nib%0d: got %h oe=%b expected %h oe=1", i, rd_buf[i], rd_oe[i], exp_nib[i]);
            end
        end
        $display("test_reset_mid_read done");
    endtask

    initial begin
        test_reset();
        test_backdoor();
        test_read();
        test_write_cross();
        test_write_wrap();
        test_partial();
        test_bd_blocked();
        test_bad_instr();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
